// File: rtl/read_port_buffer_if.sv
// read_port_buffer_if: client request/response and memory read-port signals of
// one read_port_buffer. The slave modport is the buffer's view; the master
// modport is the environment (client plus memory) driving it.
//
// Handshake rules: a request transfers on a rising edge where c_valid & c_ready;
// an address issues where r_avalid & r_aready, and once r_avalid rises both it
// and r_addr hold until that issue; a response is consumed where
// c_dvalid & c_dready; r_dvalid has no ready and is always taken.
interface read_port_buffer_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] c_addr;
    logic                  c_valid;
    logic                  c_ready;
    logic [DATA_WIDTH-1:0] c_data;
    logic                  c_dvalid;
    logic                  c_dready;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_avalid;
    logic                  r_aready;
    logic                  r_dvalid;
    logic [DATA_WIDTH-1:0] r_data;

    modport slave (
        input  c_addr, c_valid, c_dready, r_aready, r_dvalid, r_data,
        output c_ready, c_data, c_dvalid, r_addr, r_avalid
    );

    modport master (
        output c_addr, c_valid, c_dready, r_aready, r_dvalid, r_data,
        input  c_ready, c_data, c_dvalid, r_addr, r_avalid
    );
endinterface

// File: rtl/read_port_buffer.sv
// read_port_buffer: per-requester read front-end for one multibank_memory read
// port. Client addresses queue in a request FIFO and issue on r_addr/r_avalid;
// returned beats land in a response FIFO drained by the client. Issue is gated
// by credit (in-flight reads + buffered responses < RESP_DEPTH) so a memory
// return, which cannot be stalled, always finds a free slot.
//
// Optional feature: define READ_PORT_BUFFER_BYPASS_EN to let a request skip the
// empty request FIFO and issue in the same cycle it is presented.
module read_port_buffer #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int REQ_DEPTH  = 4,
    parameter int RESP_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    read_port_buffer_if.slave                 bus,
    output logic [$clog2(RESP_DEPTH+1)-1:0]   outstanding,
    output logic                              err_unexpected
);
    localparam int RAW = $clog2(REQ_DEPTH);
    localparam int RSW = $clog2(RESP_DEPTH);
    localparam int OW  = $clog2(RESP_DEPTH + 1);

    // Storage arrays carry no reset: occupancy is tracked by the pointers.
    logic [ADDR_WIDTH-1:0] req_mem  [REQ_DEPTH];
    logic [DATA_WIDTH-1:0] resp_mem [RESP_DEPTH];

    // Pointers carry one extra bit so full and empty are distinguishable.
    logic [RAW:0]  req_wr_q,  req_wr_d,  req_rd_q,  req_rd_d;
    logic [RSW:0]  resp_wr_q, resp_wr_d, resp_rd_q, resp_rd_d;
    logic [OW-1:0] outstanding_q, outstanding_d;
    logic          err_q, err_d;

    logic          req_empty, req_full, resp_empty;
    logic [RSW:0]  resp_count;
    logic [OW:0]   credit_sum;
    logic          credit_ok, bypass, issue;
    logic          req_push, req_pop, resp_push, resp_pop;

    // Occupancy, credit, issue/return decisions and next-state values.
    always_comb begin
        req_empty  = (req_wr_q == req_rd_q);
        req_full   = (req_wr_q[RAW] != req_rd_q[RAW]) &&
                     (req_wr_q[RAW-1:0] == req_rd_q[RAW-1:0]);
        resp_empty = (resp_wr_q == resp_rd_q);
        resp_count = resp_wr_q - resp_rd_q;

        // Credit only falls on an issue, so a waiting r_avalid never drops.
        credit_sum = (OW+1)'(outstanding_q) + (OW+1)'(resp_count);
        credit_ok  = (credit_sum < (OW+1)'(RESP_DEPTH));

`ifdef READ_PORT_BUFFER_BYPASS_EN
        bypass = req_empty & credit_ok & bus.c_valid;
`else
        bypass = 1'b0;
`endif

        bus.c_ready  = ~req_full;
        bus.r_avalid = (~req_empty & credit_ok) | bypass;
        if (bypass) begin
            bus.r_addr = bus.c_addr;
        end else if (bus.r_avalid) begin
            bus.r_addr = req_mem[req_rd_q[RAW-1:0]];
        end else begin
            bus.r_addr = '0;
        end
        issue = bus.r_avalid & bus.r_aready;

        // A bypassed request that issues immediately never occupies the FIFO.
        req_push = bus.c_valid & ~req_full & ~(bypass & bus.r_aready);
        req_pop  = issue & ~bypass;

        // Returns with nothing in flight are dropped and flagged.
        resp_push = bus.r_dvalid & (outstanding_q != '0);
        resp_pop  = ~resp_empty & bus.c_dready;

        bus.c_dvalid = ~resp_empty;
        bus.c_data   = resp_empty ? '0 : resp_mem[resp_rd_q[RSW-1:0]];

        req_wr_d      = req_wr_q  + (RAW+1)'(req_push);
        req_rd_d      = req_rd_q  + (RAW+1)'(req_pop);
        resp_wr_d     = resp_wr_q + (RSW+1)'(resp_push);
        resp_rd_d     = resp_rd_q + (RSW+1)'(resp_pop);
        outstanding_d = outstanding_q + OW'(issue) - OW'(resp_push);
        err_d         = err_q | (bus.r_dvalid & (outstanding_q == '0));

        outstanding    = outstanding_q;
        err_unexpected = err_q;
    end

    // Control state: pointers, in-flight count and sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_wr_q      <= '0;
            req_rd_q      <= '0;
            resp_wr_q     <= '0;
            resp_rd_q     <= '0;
            outstanding_q <= '0;
            err_q         <= 1'b0;
        end else begin
            req_wr_q      <= req_wr_d;
            req_rd_q      <= req_rd_d;
            resp_wr_q     <= resp_wr_d;
            resp_rd_q     <= resp_rd_d;
            outstanding_q <= outstanding_d;
            err_q         <= err_d;
        end
    end

    // Request FIFO storage write.
    always_ff @(posedge clk) begin
        if (req_push) begin
            req_mem[req_wr_q[RAW-1:0]] <= bus.c_addr;
        end
    end

    // Response FIFO storage write.
    always_ff @(posedge clk) begin
        if (resp_push) begin
            resp_mem[resp_wr_q[RSW-1:0]] <= bus.r_data;
        end
    end
endmodule

// File: tb/tb_read_port_buffer.sv
// Testbench for read_port_buffer: queue-level reference model checked every
// cycle, a memory responder with programmable latency, and directed scenarios
// with hand-computed literal expectations.
module tb_read_port_buffer;
    localparam int DW = 16;
    localparam int AW = 16;
    localparam int RQ = 4;
    localparam int RS = 4;
    localparam int OW = $clog2(RS + 1);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    read_port_buffer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
    logic [OW-1:0] outstanding;
    logic          err_unexpected;

    read_port_buffer #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REQ_DEPTH(RQ), .RESP_DEPTH(RS)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .outstanding    (outstanding),
        .err_unexpected (err_unexpected)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- reference model ----------------
    logic [AW-1:0] req_q[$];
    logic [DW-1:0] exp_q[$];
    int            m_out = 0;
    bit            m_err = 1'b0;

    function automatic bit m_credit();
        return (m_out + exp_q.size()) < RS;
    endfunction

    function automatic bit m_cready();
        return req_q.size() < RQ;
    endfunction

    function automatic bit m_avalid();
        if (req_q.size() > 0) return m_credit();
`ifdef READ_PORT_BUFFER_BYPASS_EN
        return bus.c_valid && m_credit();
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [AW-1:0] m_addr();
        if (req_q.size() > 0) return req_q[0];
        return bus.c_addr;
    endfunction

    always @(posedge clk) begin
        bit cr, iss, byp, dpop;
        if (rst) begin
            req_q.delete();
            exp_q.delete();
            m_out = 0;
            m_err = 1'b0;
        end else begin
            cr   = m_cready();
            iss  = m_avalid() && bus.r_aready;
            byp  = iss && (req_q.size() == 0);
            dpop = (exp_q.size() > 0) && bus.c_dready;
            if (iss && !byp) void'(req_q.pop_front());
            if (bus.c_valid && cr && !byp) req_q.push_back(bus.c_addr);
            if (dpop) void'(exp_q.pop_front());
            if (bus.r_dvalid) begin
                if (m_out == 0) m_err = 1'b1;
                else begin
                    exp_q.push_back(bus.r_data);
                    m_out--;
                end
            end
            if (iss) m_out++;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("c_ready", 32'(bus.c_ready), 32'(m_cready()));
            chk("c_dvalid", 32'(bus.c_dvalid), 32'(exp_q.size() > 0));
            if (exp_q.size() > 0) chk("c_data", 32'(bus.c_data), 32'(exp_q[0]));
            chk("r_avalid", 32'(bus.r_avalid), 32'(m_avalid()));
            if (m_avalid()) chk("r_addr", 32'(bus.r_addr), 32'(m_addr()));
            chk("outstanding", 32'(outstanding), 32'(m_out));
            chk("err_unexpected", 32'(err_unexpected), 32'(m_err));
        end
    end

    // ---------------- memory responder ----------------
    int            cyc     = 0;
    int            mem_lat = 1;
    logic [DW-1:0] mem_xor = '0;
    logic [DW-1:0] pend_d[$];
    int            pend_t[$];
    int            hs_cnt  = 0;
    int            inj_req = 0;
    int            inj_done = 0;

    initial begin
        bus.r_dvalid = 1'b0;
        bus.r_data   = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend_d.delete();
                pend_t.delete();
            end else if (bus.r_avalid && bus.r_aready) begin
                pend_d.push_back(bus.r_addr ^ mem_xor);
                pend_t.push_back(cyc + mem_lat);
                hs_cnt++;
            end
            @(posedge clk);
            cyc++;
            #1;
            if (inj_req != inj_done) begin
                bus.r_dvalid = 1'b1;
                bus.r_data   = 16'hDEAD;
                inj_done     = inj_req;
            end else if (pend_d.size() > 0 && pend_t[0] <= cyc) begin
                bus.r_dvalid = 1'b1;
                bus.r_data   = pend_d.pop_front();
                void'(pend_t.pop_front());
            end else begin
                bus.r_dvalid = 1'b0;
                bus.r_data   = '0;
            end
        end
    end

    // Responses consumed by the client, in order.
    logic [DW-1:0] got_q[$];
    always @(negedge clk) begin
        if (!rst && bus.c_dvalid && bus.c_dready) got_q.push_back(bus.c_data);
    end

    // ---------------- driver tasks ----------------
    task automatic pin_reset(input string tag);
        chk({tag, "_c_ready"}, 32'(bus.c_ready), 32'd1);
        chk({tag, "_c_dvalid"}, 32'(bus.c_dvalid), 32'd0);
        chk({tag, "_c_data"}, 32'(bus.c_data), 32'd0);
        chk({tag, "_r_avalid"}, 32'(bus.r_avalid), 32'd0);
        chk({tag, "_r_addr"}, 32'(bus.r_addr), 32'd0);
        chk({tag, "_outstanding"}, 32'(outstanding), 32'd0);
        chk({tag, "_err"}, 32'(err_unexpected), 32'd0);
    endtask

    task automatic wait_dvalid(input string tag, input int limit);
        int n = 0;
        while (!bus.c_dvalid && n < limit) begin
            tick(1);
            n++;
        end
        chk({tag, "_dvalid_timeout"}, 32'(bus.c_dvalid), 32'd1);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int hs0;
        int base;
        bus.c_addr   = '0;
        bus.c_valid  = 1'b0;
        bus.c_dready = 1'b0;
        bus.r_aready = 1'b0;
        rst = 1'b1;
        tick(1);
        chk_en = 1'b1;
        tick(1);
        rst = 1'b0;
        pin_reset("init");

        // Single read, memory returns two cycles after accept.
        mem_lat = 2;
        mem_xor = '0;
        bus.r_aready = 1'b1;
        bus.c_addr  = 16'h0005;
        bus.c_valid = 1'b1;
        tick(1);
        bus.c_valid = 1'b0;
        wait_dvalid("single", 20);
        chk("single_c_data", 32'(bus.c_data), 32'h0005);
        chk("single_outstanding", 32'(outstanding), 32'd0);
        chk("single_err", 32'(err_unexpected), 32'd0);
        bus.c_dready = 1'b1;
        tick(1);
        bus.c_dready = 1'b0;
        chk("single_drained", 32'(bus.c_dvalid), 32'd0);

        // Credit stall: six requests, client not draining.
        mem_lat = 1;
        mem_xor = 16'h0100;
        hs0  = hs_cnt;
        base = got_q.size();
        for (int i = 0; i < 6; i++) begin
            bus.c_addr  = 16'h0020 + 16'(i);
            bus.c_valid = 1'b1;
            tick(1);
        end
        bus.c_valid = 1'b0;
        tick(6);
        chk("credit_hs4", 32'(hs_cnt - hs0), 32'd4);
        chk("credit_avalid_low", 32'(bus.r_avalid), 32'd0);
        bus.c_dready = 1'b1;
        tick(1);
        bus.c_dready = 1'b0;
        tick(4);
        chk("credit_hs5", 32'(hs_cnt - hs0), 32'd5);
        chk("credit_avalid_low2", 32'(bus.r_avalid), 32'd0);
        bus.c_dready = 1'b1;
        tick(12);
        chk("credit_count", 32'(got_q.size() - base), 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (base + i < got_q.size())
                chk("credit_order", 32'(got_q[base+i]), 32'h0120 + 32'(i));
        end

        // Back-to-back: sixteen reads at full rate.
        mem_xor = '0;
        hs0  = hs_cnt;
        base = got_q.size();
        for (int i = 0; i < 16; i++) begin
            bus.c_addr  = 16'(i);
            bus.c_valid = 1'b1;
            tick(1);
        end
        bus.c_valid = 1'b0;
        tick(1);
        chk("b2b_rate", 32'(hs_cnt - hs0), 32'd16);
        tick(6);
        chk("b2b_count", 32'(got_q.size() - base), 32'd16);
        for (int i = 0; i < 16; i++) begin
            if (base + i < got_q.size())
                chk("b2b_order", 32'(got_q[base+i]), 32'(i));
        end

        // Address backpressure: memory not ready for five cycles.
        bus.r_aready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.c_addr  = 16'h0030 + 16'(i);
            bus.c_valid = 1'b1;
            tick(1);
            chk("bp_r_avalid", 32'(bus.r_avalid), 32'd1);
            chk("bp_r_addr_stable", 32'(bus.r_addr), 32'h0030);
        end
        chk("bp_c_ready_low", 32'(bus.c_ready), 32'd0);
        bus.c_valid  = 1'b0;
        bus.r_aready = 1'b1;
        tick(12);

        // Unexpected return with nothing in flight.
        chk("err_pre_idle", 32'(outstanding), 32'd0);
        inj_req++;
        tick(3);
        chk("err_set", 32'(err_unexpected), 32'd1);
        chk("err_no_data", 32'(bus.c_dvalid), 32'd0);
        chk("err_outstanding", 32'(outstanding), 32'd0);

        // Reset with two requests queued.
        bus.r_aready = 1'b0;
        bus.c_addr   = 16'h0040;
        bus.c_valid  = 1'b1;
        tick(1);
        bus.c_addr   = 16'h0041;
        tick(1);
        bus.c_valid  = 1'b0;
        chk("rst_pre_queued", 32'(bus.r_avalid), 32'd1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        pin_reset("midrst");
        tick(2);

`ifdef READ_PORT_BUFFER_BYPASS_EN
        // Zero-latency issue from an empty FIFO.
        bus.r_aready = 1'b1;
        bus.c_addr   = 16'h0077;
        bus.c_valid  = 1'b1;
        #1;
        chk("bypass_avalid", 32'(bus.r_avalid), 32'd1);
        chk("bypass_addr", 32'(bus.r_addr), 32'h0077);
        tick(1);
        bus.c_valid = 1'b0;
        tick(6);
`endif

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
